// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and sizing helpers for the direct-mapped cache controller.
//   cache_state_t : controller FSM state encoding (also exported for debug)
//   OFF_W / WORDS : block offset width and words per block
//   idx_width / tag_width / off_width / cnt_width : field width helpers
// -----------------------------------------------------------------------------
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } cache_state_t;

  localparam int OFF_W = 2;
  localparam int WORDS = 4;

  // Index width; a single-line cache still needs a 1-bit index vector.
  function automatic int idx_width(input int lines);
    return (lines > 1) ? $clog2(lines) : 1;
  endfunction

  // Tag is whatever remains of the word address above index and offset.
  function automatic int tag_width(input int aw, input int lines);
    return aw - idx_width(lines) - OFF_W;
  endfunction

  function automatic int off_width();
    return OFF_W;
  endfunction

  // Latency counter must hold 0..lat inclusive.
  function automatic int cnt_width(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/cache_data_array.sv
// -----------------------------------------------------------------------------
// cache_data_array
// Valid / tag / data storage for a direct-mapped cache with 4-word blocks.
//   clk, rst                       : clock, async active-high clear of valid bits
//   rd_idx -> rd_valid/rd_tag/rd_block : combinational read of one line
//   fill_en/fill_idx/fill_tag/fill_block : whole-line refill, sets valid + tag
//   wr_en/wr_idx/wr_off/wr_data    : single-word update of a resident line
// Fill and word-write are never requested in the same cycle by the controller.
// -----------------------------------------------------------------------------
module cache_data_array
  import cache_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LINES = 16,
  parameter int TW    = 4,
  parameter int IW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [IW-1:0]          rd_idx,
  output logic                   rd_valid,
  output logic [TW-1:0]          rd_tag,
  output logic [WORDS*WIDTH-1:0] rd_block,
  input  logic                   fill_en,
  input  logic [IW-1:0]          fill_idx,
  input  logic [TW-1:0]          fill_tag,
  input  logic [WORDS*WIDTH-1:0] fill_block,
  input  logic                   wr_en,
  input  logic [IW-1:0]          wr_idx,
  input  logic [OFF_W-1:0]       wr_off,
  input  logic [WIDTH-1:0]       wr_data
);

  logic [LINES-1:0]       valid_q;
  logic [TW-1:0]          tag_q  [LINES];
  logic [WORDS*WIDTH-1:0] data_q [LINES];

  // Only the valid bits need clearing; tag/data contents are don't-care
  // until a line becomes valid again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_block;
    end else if (wr_en) begin
      data_q[wr_idx][int'(wr_off)*WIDTH +: WIDTH] <= wr_data;
    end
  end

  always_comb begin
    rd_valid = valid_q[rd_idx];
    rd_tag   = tag_q[rd_idx];
    rd_block = data_q[rd_idx];
  end

endmodule

// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Direct-mapped, write-through, no-write-allocate cache between the core data
// port and a fixed-latency main memory (no ready signal; timed internally).
//   clk, rst        : clock, async active-high reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : core request (word address)
//   cpu_rdata       : load data, valid when cpu_stall=0 on a load, else 0
//   cpu_stall       : core must hold its request while high
//   mem_ren/mem_wen/mem_addr/mem_wdata : block-read / word-write to main_mem
//   mem_rblock      : returned 4-word block, word k at [k*WIDTH +: WIDTH]
//   dbg_state       : current FSM state
//   hit_cnt/miss_cnt: load hit/miss counters, present only with the
//                     CACHE_STATS_EN macro defined
//
// Core handshake: the core raises cpu_req with a stable command. A request
// completes in the first cycle where cpu_req=1 and cpu_stall=0; the core may
// then present a new request (or drop cpu_req) after that rising edge. While
// cpu_stall=1 the core must hold cpu_req/cpu_we/cpu_addr/cpu_wdata unchanged.
// -----------------------------------------------------------------------------
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 1024,
  parameter int LINES   = 16,
  parameter int MEM_LAT = 4,
  parameter int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [AW-1:0]          cpu_addr,
  input  logic [WIDTH-1:0]       cpu_wdata,
  output logic [WIDTH-1:0]       cpu_rdata,
  output logic                   cpu_stall,
  output logic                   mem_ren,
  output logic                   mem_wen,
  output logic [AW-1:0]          mem_addr,
  output logic [WIDTH-1:0]       mem_wdata,
  input  logic [WORDS*WIDTH-1:0] mem_rblock,
  output cache_state_t           dbg_state
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]            hit_cnt,
  output logic [31:0]            miss_cnt
`endif
);

  localparam int IW = idx_width(LINES);
  localparam int TW = tag_width(AW, LINES);
  localparam int CW = cnt_width(MEM_LAT);
  localparam logic [CW-1:0] LAST_CNT = CW'(MEM_LAT);

  // Address fields.
  logic [TW-1:0]    addr_tag;
  logic [IW-1:0]    addr_idx;
  logic [OFF_W-1:0] addr_off;

  assign addr_tag = cpu_addr[AW-1 -: TW];
  assign addr_idx = cpu_addr[OFF_W +: IW];
  assign addr_off = cpu_addr[OFF_W-1:0];

  // Line lookup.
  logic                   line_valid;
  logic [TW-1:0]          line_tag;
  logic [WORDS*WIDTH-1:0] line_block;
  logic                   hit;
  logic [WIDTH-1:0]       line_word;

  assign hit       = line_valid && (line_tag == addr_tag);
  assign line_word = line_block[int'(addr_off)*WIDTH +: WIDTH];

  // FSM / counter state.
  cache_state_t  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Raw (pre-reset-gating) outputs and array controls.
  logic             stall_c;
  logic [WIDTH-1:0] rdata_c;
  logic             ren_c;
  logic             wen_c;
  logic [AW-1:0]    maddr_c;
  logic [WIDTH-1:0] mwdata_c;
  logic             fill_c;
  logic             wr_hit_c;
  logic             load_hit_c;
  logic             load_miss_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    stall_c     = 1'b0;
    rdata_c     = '0;
    ren_c       = 1'b0;
    wen_c       = 1'b0;
    maddr_c     = '0;
    mwdata_c    = '0;
    fill_c      = 1'b0;
    wr_hit_c    = 1'b0;
    load_hit_c  = 1'b0;
    load_miss_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            // Write-through: a resident word is updated now, memory later.
            stall_c  = 1'b1;
            wr_hit_c = hit;
            state_d  = ST_WRITE;
          end else if (hit) begin
            rdata_c    = line_word;
            load_hit_c = 1'b1;
          end else begin
            stall_c     = 1'b1;
            load_miss_c = 1'b1;
            state_d     = ST_FETCH;
          end
        end
      end

      ST_FETCH: begin
        stall_c = 1'b1;
        ren_c   = 1'b1;
        maddr_c = {addr_tag, addr_idx, {OFF_W{1'b0}}};
        if (cnt_q == LAST_CNT) begin
          // Memory data is valid on the edge ending the last strobe cycle.
          fill_c  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WRITE: begin
        stall_c  = 1'b1;
        wen_c    = 1'b1;
        maddr_c  = cpu_addr;
        mwdata_c = cpu_wdata;
        if (cnt_q == LAST_CNT) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        // Completion cycle: the held request is answered, not re-decoded.
        if (!cpu_we) begin
          rdata_c = line_word;
        end
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  cache_data_array #(
    .WIDTH (WIDTH),
    .LINES (LINES),
    .TW    (TW),
    .IW    (IW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_idx     (addr_idx),
    .rd_valid   (line_valid),
    .rd_tag     (line_tag),
    .rd_block   (line_block),
    .fill_en    (fill_c && !rst),
    .fill_idx   (addr_idx),
    .fill_tag   (addr_tag),
    .fill_block (mem_rblock),
    .wr_en      (wr_hit_c && !rst),
    .wr_idx     (addr_idx),
    .wr_off     (addr_off),
    .wr_data    (cpu_wdata)
  );

  // Outputs are forced low while reset is asserted, independent of cpu_req,
  // so memory strobes drop the moment reset arrives.
  assign cpu_stall = rst ? 1'b0 : stall_c;
  assign cpu_rdata = rst ? '0   : rdata_c;
  assign mem_ren   = rst ? 1'b0 : ren_c;
  assign mem_wen   = rst ? 1'b0 : wen_c;
  assign mem_addr  = rst ? '0   : maddr_c;
  assign mem_wdata = rst ? '0   : mwdata_c;
  assign dbg_state = state_q;

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (load_hit_c) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (load_miss_c) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end
`else
  logic stats_unused;
  assign stats_unused = load_hit_c ^ load_miss_c;
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
// Directed bench for cache_ctrl with a simple word memory model behind the
// mem_* port. Memory is preloaded with mem[a] = 0x1000_0000 + a.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic                   cpu_req = 1'b0;
  logic                   cpu_we = 1'b0;
  logic [AW-1:0]          cpu_addr = '0;
  logic [WIDTH-1:0]       cpu_wdata = '0;
  logic [WIDTH-1:0]       cpu_rdata;
  logic                   cpu_stall;
  logic                   mem_ren;
  logic                   mem_wen;
  logic [AW-1:0]          mem_addr;
  logic [WIDTH-1:0]       mem_wdata;
  logic [4*WIDTH-1:0]     mem_rblock;
  cache_state_t           dbg_state;
`ifdef CACHE_STATS_EN
  logic [31:0]            hit_cnt;
  logic [31:0]            miss_cnt;
`endif

  cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_ren    (mem_ren),
    .mem_wen    (mem_wen),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rblock (mem_rblock),
    .dbg_state  (dbg_state)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  // Memory model
  logic [WIDTH-1:0] mem [DEPTH];
  logic             mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rblock = '0;
    for (int k = 0; k < 4; k++) begin
      mem_rblock[k*WIDTH +: WIDTH] = mem[{mem_addr[AW-1:2], 2'(k)}];
    end
  end

  // Scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge. Presents one request, watches it to
  // completion on falling edges, then drops cpu_req just after the edge
  // that consumed it.
  task automatic access(input string name, input logic we, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata,
                        input int exp_stall, input int exp_ren, input int exp_wen);
    int  n_stall, n_ren, n_wen, n_bad, n_both;
    bit  done;
    logic [AW-1:0] blk;
    blk = {addr[AW-1:2], 2'b00};
    n_stall = 0; n_ren = 0; n_wen = 0; n_bad = 0; n_both = 0; done = 0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_ren && mem_wen) n_both++;
      if (mem_ren) begin
        n_ren++;
        if (mem_addr !== blk) n_bad++;
      end
      if (mem_wen) begin
        n_wen++;
        if (mem_addr !== addr || mem_wdata !== wdata) n_bad++;
      end
      if (cpu_stall) n_stall++;
      else begin
        done = 1;
        check({name, "_rdata"}, cpu_rdata, exp_rdata);
      end
    end
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_stall"}, 32'(n_stall), 32'(exp_stall));
    check({name, "_ren"}, 32'(n_ren), 32'(exp_ren));
    check({name, "_wen"}, 32'(n_wen), 32'(exp_wen));
    check({name, "_addr"}, 32'(n_bad), 32'd0);
    check({name, "_excl"}, 32'(n_both), 32'd0);
    @(posedge clk);
    #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_stall"}, 32'(cpu_stall), 32'd0);
    check({name, "_rdata"}, cpu_rdata, 32'd0);
    check({name, "_ren"}, 32'(mem_ren), 32'd0);
    check({name, "_wen"}, 32'(mem_wen), 32'd0);
    check({name, "_maddr"}, 32'(mem_addr), 32'd0);
    check({name, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    // Reset with a load request held, outputs must stay quiet.
    cpu_req = 1'b1; cpu_addr = 10'h010;
    @(posedge clk);
    #1 mem_init = 1'b0;
    @(negedge clk);
    check_outputs_zero("rst");
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    cpu_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Cold miss, then hit in the same block.
    access("ld010_miss", 1'b0, 10'h010, 32'h0, 32'h1000_0010, 6, 5, 0);
    access("ld012_hit",  1'b0, 10'h012, 32'h0, 32'h1000_0012, 0, 0, 0);

    // Store hit updates cache and memory.
    access("st011_hit", 1'b1, 10'h011, 32'hDEAD_BEEF, 32'h0, 6, 0, 5);
    check("st011_mem", mem[10'h011], 32'hDEAD_BEEF);
    access("ld011_hit", 1'b0, 10'h011, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);

    // Store miss writes memory only; the next load must fetch.
    access("st050_miss", 1'b1, 10'h050, 32'h1234_5678, 32'h0, 6, 0, 5);
    check("st050_mem", mem[10'h050], 32'h1234_5678);
    @(negedge clk);
    check("idle_rdata", cpu_rdata, 32'h0);
    check("idle_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    access("ld050_miss", 1'b0, 10'h050, 32'h0, 32'h1234_5678, 6, 5, 0);

    // Conflict on index 4: 0x110 evicts 0x010.
    access("ld110_miss", 1'b0, 10'h110, 32'h0, 32'h1000_0110, 6, 5, 0);
    access("ld010_evict", 1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF & 32'h0 | 32'h1000_0010, 6, 5, 0);
    access("ld010_hit2", 1'b0, 10'h010, 32'h0, 32'h1000_0010, 0, 0, 0);

    // Reset in the 3rd FETCH cycle of a miss on 0x020.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h020;
    repeat (3) @(posedge clk);
    #2;
    check("midf_ren", 32'(mem_ren), 32'd1);
    rst = 1'b1;
    #1;
    check_outputs_zero("midf_rst");
    @(posedge clk);
    #1;
    check("midf_state", 32'(dbg_state), 32'(ST_IDLE));
    cpu_req = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Valid bits cleared: previously resident line misses again.
    access("ld010_post", 1'b0, 10'h010, 32'h0, 32'h1000_0010, 6, 5, 0);
    access("ld012_post", 1'b0, 10'h012, 32'h0, 32'h1000_0012, 0, 0, 0);
    // The aborted fetch left line 8 empty.
    access("ld020_post", 1'b0, 10'h020, 32'h0, 32'h1000_0020, 6, 5, 0);

`ifdef CACHE_STATS_EN
    @(negedge clk);
    check("stat_hit", hit_cnt, 32'd1);
    check("stat_miss", miss_cnt, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Direct-mapped, write-through, no-write-allocate cache controller between the RISC-V core's data port and `main_mem`. It serves read hits in zero stall cycles. On a read miss it fetches a 4-word block through `main_mem`'s block-read port. It forwards every store to memory as a single-word write. `main_mem` has fixed latency and no ready signal, so the controller times each memory access with an internal counter.

## Interface
- `WIDTH`, 32, data word width.
- `DEPTH`, 1024, main-memory depth in words; address width `AW = $clog2(DEPTH)`.
- `LINES`, 16, number of cache lines (power of two).
- `MEM_LAT`, 4, main-memory access latency in clock edges.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: access request, held by core while `cpu_stall`=1.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in AW: word address; fields {tag, index[$clog2(LINES)], offset[2]}.
- `cpu_wdata` in WIDTH: store data.
- `cpu_rdata` out WIDTH: load data; valid when `cpu_stall`=0 on a load.
- `cpu_stall` out 1: core must hold request.
- `mem_ren` out 1: block read to `main_mem`.
- `mem_wen` out 1: word write to `main_mem`.
- `mem_addr` out AW: word address to `main_mem`.
- `mem_wdata` out WIDTH: write data to `main_mem`.
- `mem_rblock` in 4*WIDTH: returned block; word k in bits [k*WIDTH +: WIDTH].

## Operation
- Storage per line: valid bit, tag, 4-word data block.
- FSM states: IDLE, FETCH, WRITE, RESP.
- IDLE, no `cpu_req`: stay in IDLE; `cpu_stall`=0; memory strobes low.
- IDLE, load hit (valid && tag match): `cpu_rdata` = line word[offset] in the same cycle; `cpu_stall`=0; stay in IDLE.
- IDLE, load miss: `cpu_stall`=1; go to FETCH.
- IDLE, store (hit or miss): `cpu_stall`=1; go to WRITE. On a hit, the cache word is updated in this cycle.
- FETCH: `mem_ren`=1 and `mem_addr` = {tag, index, 2'b00} for exactly MEM_LAT+1 cycles. On the edge ending the last of those cycles:
  - `mem_rblock` is written into the line;
  - the valid bit is set and the tag is stored;
  - the FSM goes to RESP.
- WRITE: `mem_wen`=1, `mem_addr`=`cpu_addr` and `mem_wdata`=`cpu_wdata` for exactly MEM_LAT+1 cycles, then RESP. There is no allocation on a store miss.
- RESP: `cpu_stall`=0 for one cycle.
  - Load: `cpu_rdata` = refilled word[offset].
  - The FSM returns to IDLE. The request present in RESP is the completed one and is not re-evaluated.
- `cpu_rdata` = 0 whenever no load is completing.
- Write-through means the cache is never dirty; no eviction writeback is needed.

## Timing
- Reset (async, immediate): FSM=IDLE, all valid bits=0, counter=0.
- Output values during reset: `cpu_stall`=0, `cpu_rdata`=0, `mem_ren`=0, `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
- Load hit: 0 stall cycles.
- Load miss and store: `cpu_stall`=1 for MEM_LAT+2 cycles (6 at default), then 1 RESP cycle.
- `mem_ren` and `mem_wen` are never high together. Address and data stay stable for the whole strobe window.
- Reset mid-FETCH or mid-WRITE:
  - the operation is abandoned and the line is not filled;
  - strobes drop immediately;
  - the partial memory write is undefined.
- `cpu_req` dropping during a stall violates the protocol; behaviour is undefined.

## Configuration
- `CACHE_STATS_EN` defined: adds 32-bit outputs `hit_cnt` and `miss_cnt`.
  - Loads only: a hit increments `hit_cnt` in its IDLE cycle; a miss increments `miss_cnt` on IDLE→FETCH.
  - Counters wrap at 2^32 and reset to 0.
- `CACHE_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Package `cache_pkg`:
  - state enum `cache_state_t`;
  - offset width constant (2) and words-per-block constant (4);
  - helper functions for the tag, index and offset widths.
- Sub-module `cache_data_array`: valid/tag/data storage.
  - Combinational read by index.
  - Synchronous block-fill and word-write ports.
  - Async clear of the valid bits.
- The FSM and latency counter live in `cache_ctrl`.

## Test plan
- Reset, then load addr 0x010 with mem[0x010..0x013] preloaded -> stall high for 6 cycles, `mem_ren` high for 5 with `mem_addr`=0x010, RESP `cpu_rdata`=mem[0x010].
- Load 0x012 right after the previous test -> hit: `cpu_rdata`=mem[0x012], stall 0, no `mem_ren`.
- Store 0xDEADBEEF to 0x011 (hit) -> `mem_wen` held 5 cycles; then load 0x011 hits and returns 0xDEADBEEF.
- Store to 0x050 (miss) -> memory is written, no fill; the next load of 0x050 misses and fetches.
- Load 0x010 then 0x110 (same index, different tag) -> both miss; reload of 0x010 misses again (eviction).
- Assert `rst` in the 3rd FETCH cycle -> all outputs 0 immediately; after release, load 0x010 misses.
